// File: rtl/pac_pkg.sv
// pac_pkg: shared types and constants for the Pac-Man movement logic.
//   dir_t   - heading encoding (UP=0, RIGHT=1, DOWN=2, LEFT=3)
//   state_t - movement controller FSM states
//   MAZE_W, MAZE_ROWS, COORD_W - maze geometry and coordinate width
package pac_pkg;

  localparam int unsigned MAZE_W    = 32;
  localparam int unsigned MAZE_ROWS = 24;
  localparam int unsigned COORD_W   = 5;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_ADDR,
    S_REQ_CHK,
    S_CUR_ADDR,
    S_CUR_CHK
  } state_t;

endpackage

// File: rtl/pac_move_ctrl_if.sv
// pac_move_ctrl_if: game-side and ROM-side signals of the movement controller.
//   tick, dir_in, dir_valid : move request and joystick turn buffer load
//   rom_addr / rom_data     : maze row address out, registered row word back
//   pac_x, pac_y, pac_dir   : committed position and heading
//   moved, blocked, busy    : status pulses and activity flag
// slave  = the controller, master = the surrounding game/ROM logic.
interface pac_move_ctrl_if;

  logic                        tick;
  logic [1:0]                  dir_in;
  logic                        dir_valid;
  logic [pac_pkg::COORD_W-1:0] rom_addr;
  logic [pac_pkg::MAZE_W-1:0]  rom_data;
  logic [pac_pkg::COORD_W-1:0] pac_x;
  logic [pac_pkg::COORD_W-1:0] pac_y;
  logic [1:0]                  pac_dir;
  logic                        moved;
  logic                        blocked;
  logic                        busy;

  modport slave (
    input  tick, dir_in, dir_valid, rom_data,
    output rom_addr, pac_x, pac_y, pac_dir, moved, blocked, busy
  );

  modport master (
    output tick, dir_in, dir_valid, rom_data,
    input  rom_addr, pac_x, pac_y, pac_dir, moved, blocked, busy
  );

endinterface

// File: rtl/pac_step.sv
// pac_step: combinational one-cell step.
//   i_x, i_y        : current cell
//   i_dir           : direction of the step
//   o_tx, o_ty      : target cell (low 5 bits)
//   o_out_of_range  : step leaves the 0..31 coordinate space
// Arithmetic runs at 6 bits so that wrap-around at either edge shows up
// in bit 5 instead of silently aliasing to the opposite side.
module pac_step
  import pac_pkg::*;
(
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  input  dir_t               i_dir,
  output logic [COORD_W-1:0] o_tx,
  output logic [COORD_W-1:0] o_ty,
  output logic               o_out_of_range
);

  logic [COORD_W:0] w_x6;
  logic [COORD_W:0] w_y6;

  always_comb begin
    w_x6 = {1'b0, i_x};
    w_y6 = {1'b0, i_y};
    unique case (i_dir)
      UP:    w_y6 = {1'b0, i_y} - 1'b1;
      RIGHT: w_x6 = {1'b0, i_x} + 1'b1;
      DOWN:  w_y6 = {1'b0, i_y} + 1'b1;
      LEFT:  w_x6 = {1'b0, i_x} - 1'b1;
      default: ;
    endcase
    o_tx           = w_x6[COORD_W-1:0];
    o_ty           = w_y6[COORD_W-1:0];
    o_out_of_range = w_x6[COORD_W] | w_y6[COORD_W];
  end

endmodule

// File: rtl/pac_move_ctrl.sv
// pac_move_ctrl: Pac-Man movement controller.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : pac_move_ctrl_if.slave
//                in : tick, dir_in, dir_valid, rom_data (row word, 1 = wall,
//                     column x at bit 31-x, valid one cycle after rom_addr)
//                out: rom_addr, pac_x, pac_y, pac_dir, moved, blocked, busy
// On a tick, tries the buffered turn first, then the current heading, and
// commits the first legal move. Ticks arriving while busy are dropped.
module pac_move_ctrl
  import pac_pkg::*;
#(
  parameter int unsigned START_X   = 13,
  parameter int unsigned START_Y   = 20,
  parameter int unsigned MAZE_ROWS = pac_pkg::MAZE_ROWS
) (
  input  logic             clk,
  input  logic             reset,
  pac_move_ctrl_if.slave   bus
);

  localparam logic [COORD_W-1:0] COL_MAX = COORD_W'(MAZE_W - 1);

  state_t               r_state;
  logic                 r_tick;
  dir_t                 r_req_dir;
  dir_t                 r_try_dir;
  dir_t                 r_cur_dir;
  logic [COORD_W-1:0]   r_pac_x;
  logic [COORD_W-1:0]   r_pac_y;
  logic                 r_moved;
  logic                 r_blocked;
  logic                 r_busy;

  logic [COORD_W-1:0]   w_tx;
  logic [COORD_W-1:0]   w_ty;
  logic                 w_oor;
  logic                 w_legal;

  pac_step u_step (
    .i_x            (r_pac_x),
    .i_y            (r_pac_y),
    .i_dir          (r_try_dir),
    .o_tx           (w_tx),
    .o_ty           (w_ty),
    .o_out_of_range (w_oor)
  );

  // Row bound matters: the ROM returns open cells past the maze.
  assign w_legal = !w_oor && (32'(w_ty) < MAZE_ROWS) && !bus.rom_data[COL_MAX - w_tx];

  always_comb begin
    bus.rom_addr = r_pac_y;
    if (r_state != S_IDLE) bus.rom_addr = w_ty;
  end

  // tick is captured for one cycle before IDLE acts on it; capture is
  // gated to IDLE so a tick landing on the commit edge is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_tick    <= 1'b0;
      r_req_dir <= LEFT;
      r_try_dir <= LEFT;
      r_cur_dir <= LEFT;
      r_pac_x   <= COORD_W'(START_X);
      r_pac_y   <= COORD_W'(START_Y);
      r_moved   <= 1'b0;
      r_blocked <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_moved   <= 1'b0;
      r_blocked <= 1'b0;
      r_tick    <= bus.tick && (r_state == S_IDLE);
      if (bus.dir_valid) r_req_dir <= dir_t'(bus.dir_in);

      unique case (r_state)
        S_IDLE: begin
          if (r_tick) begin
            r_try_dir <= bus.dir_valid ? dir_t'(bus.dir_in) : r_req_dir;
            r_state   <= S_REQ_ADDR;
            r_busy    <= 1'b1;
          end
        end
        S_REQ_ADDR: r_state <= S_REQ_CHK;
        S_CUR_ADDR: r_state <= S_CUR_CHK;
        S_REQ_CHK, S_CUR_CHK: begin
          if (w_legal) begin
            r_pac_x   <= w_tx;
            r_pac_y   <= w_ty;
            r_cur_dir <= r_try_dir;
            r_moved   <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end else if (r_state == S_REQ_CHK && r_try_dir != r_cur_dir) begin
            r_try_dir <= r_cur_dir;
            r_state   <= S_CUR_ADDR;
          end else begin
            r_blocked <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.pac_x   = r_pac_x;
  assign bus.pac_y   = r_pac_y;
  assign bus.pac_dir = r_cur_dir;
  assign bus.moved   = r_moved;
  assign bus.blocked = r_blocked;
  assign bus.busy    = r_busy;

endmodule

// File: tb/tb_pac_move_ctrl.sv
// Testbench for pac_move_ctrl: maze ROM model plus a cell-level reference
// model of the move rules (requested turn, then heading, else blocked).
module tb_pac_move_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pac_move_ctrl_if bus ();

  pac_move_ctrl #(
    .START_X   (13),
    .START_Y   (20),
    .MAZE_ROWS (24)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] maze [32];
  int checks = 0;
  int errors = 0;
  int mx, my, mcur, mreq;

  // Registered maze ROM: rows beyond the maze read as open.
  always @(posedge clk) bus.rom_data <= maze[bus.rom_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input int x, input int y, input int d);
    int tx, ty;
    tx = x; ty = y;
    case (d)
      0: ty = ty - 1;
      1: tx = tx + 1;
      2: ty = ty + 1;
      default: tx = tx - 1;
    endcase
    if (tx < 0 || tx > 31 || ty < 0 || ty >= 24) return 1'b0;
    return maze[ty][31 - tx] == 1'b0;
  endfunction

  task automatic do_reset();
    reset = 1'b1; bus.tick = 1'b0; bus.dir_valid = 1'b0; bus.dir_in = 2'd0;
    @(posedge clk); #1;
    reset = 1'b0;
    mx = 13; my = 20; mcur = 3; mreq = 3;
  endtask

  // Starts at posedge+1; tick is sampled at the next edge (E0).
  task automatic move(input string tag, input bit dv, input logic [1:0] d,
                      input int tick_at, input int dv_at, input logic [1:0] dv_dir);
    int eff, lat, ex, ey, edir, row;
    bit em, eb;
    eff = dv ? int'(d) : mreq;
    mreq = eff;
    ex = mx; ey = my; edir = mcur; em = 1'b0; eb = 1'b0;
    if (legal(mx, my, eff)) begin lat = 3; em = 1'b1; edir = eff; end
    else if (eff == mcur)   begin lat = 3; eb = 1'b1; end
    else if (legal(mx, my, mcur)) begin lat = 5; em = 1'b1; end
    else begin lat = 5; eb = 1'b1; end
    if (em) begin
      case (edir)
        0: ey = my - 1;
        1: ex = mx + 1;
        2: ey = my + 1;
        default: ex = mx - 1;
      endcase
    end
    row = (my + ((eff == 2) ? 1 : 0) - ((eff == 0) ? 1 : 0)) & 31;

    bus.tick = 1'b1; bus.dir_valid = dv; bus.dir_in = d;
    @(posedge clk); #1;
    bus.tick = 1'b0; bus.dir_valid = 1'b0;
    for (int e = 1; e <= lat; e++) begin
      @(posedge clk); #1;
      bus.tick = 1'b0; bus.dir_valid = 1'b0;
      if (e == 1) begin
        chk({tag, "_busy_rise"}, bus.busy, 1);
        chk({tag, "_rom_addr"}, bus.rom_addr, row);
      end
      if (e < lat) begin
        chk({tag, "_moved_early"}, bus.moved, 0);
        chk({tag, "_blocked_early"}, bus.blocked, 0);
      end else begin
        chk({tag, "_moved"}, bus.moved, em);
        chk({tag, "_blocked"}, bus.blocked, eb);
        chk({tag, "_x"}, bus.pac_x, ex);
        chk({tag, "_y"}, bus.pac_y, ey);
        chk({tag, "_dir"}, bus.pac_dir, edir);
        chk({tag, "_busy_fall"}, bus.busy, 0);
      end
      if (e == tick_at) bus.tick = 1'b1;
      if (e == dv_at) begin bus.dir_valid = 1'b1; bus.dir_in = dv_dir; mreq = dv_dir; end
    end
    mx = ex; my = ey; mcur = edir;
    @(posedge clk); #1;
    bus.tick = 1'b0; bus.dir_valid = 1'b0;
    chk({tag, "_moved_pulse_end"}, bus.moved, 0);
    chk({tag, "_blocked_pulse_end"}, bus.blocked, 0);
    chk({tag, "_busy_after"}, bus.busy, 0);
    chk({tag, "_rom_addr_idle"}, bus.rom_addr, my);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Directed maze: row 20 open, row 19 open only at column 12, rest walls.
    for (int r = 0; r < 32; r++) maze[r] = (r < 24) ? 32'hFFFF_FFFF : 32'h0;
    maze[20] = 32'h0;
    maze[19] = ~(32'h1 << (31 - 12));

    do_reset();
    chk("reset_x", bus.pac_x, 13);
    chk("reset_y", bus.pac_y, 20);
    chk("reset_dir", bus.pac_dir, 3);
    chk("reset_moved", bus.moved, 0);
    chk("reset_blocked", bus.blocked, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_rom_addr", bus.rom_addr, 20);

    move("t1_right", 1'b1, 2'd1, 0, 0, 2'd0);
    do_reset();
    // UP into a wall falls back to LEFT; a RIGHT loaded mid-attempt is buffered.
    move("t2_up_fallback", 1'b1, 2'd0, 0, 3, 2'd1);
    move("t2_buffered", 1'b0, 2'd0, 0, 0, 2'd0);
    move("t2_left", 1'b1, 2'd3, 0, 0, 2'd0);
    move("t3_up", 1'b1, 2'd0, 0, 0, 2'd0);
    move("t4_down", 1'b1, 2'd2, 0, 0, 2'd0);
    move("t5_down_blocked", 1'b0, 2'd0, 0, 0, 2'd0);
    move("t6_tick_ignored", 1'b1, 2'd3, 2, 0, 2'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("t6_idle_busy", bus.busy, 0);
      chk("t6_idle_x", bus.pac_x, mx);
    end

    // Reset landing on the commit edge of a legal move.
    bus.tick = 1'b1; bus.dir_valid = 1'b1; bus.dir_in = 2'd1;
    @(posedge clk); #1;
    bus.tick = 1'b0; bus.dir_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    mx = 13; my = 20; mcur = 3; mreq = 3;
    chk("t7_reset_x", bus.pac_x, 13);
    chk("t7_reset_y", bus.pac_y, 20);
    chk("t7_reset_moved", bus.moved, 0);
    chk("t7_reset_busy", bus.busy, 0);
    chk("t7_reset_dir", bus.pac_dir, 3);
    move("t7_after_reset", 1'b0, 2'd0, 0, 0, 2'd0);

    // Edge maze: row 20, row 23 and column 0 open.
    for (int r = 0; r < 32; r++) maze[r] = (r < 24) ? 32'h7FFF_FFFF : 32'h0;
    maze[20] = 32'h0;
    maze[23] = 32'h0;
    do_reset();
    for (int i = 0; i < 14; i++) move("edge_left", 1'b1, 2'd3, 0, 0, 2'd0);
    for (int i = 0; i < 21; i++) move("edge_up", 1'b1, 2'd0, 0, 0, 2'd0);
    for (int i = 0; i < 24; i++) move("edge_down", 1'b1, 2'd2, 0, 0, 2'd0);
    for (int i = 0; i < 32; i++) move("edge_right", 1'b1, 2'd1, 0, 0, 2'd0);
    chk("edge_final_x", bus.pac_x, 31);
    chk("edge_final_y", bus.pac_y, 23);

    // Random maze, random turns.
    for (int r = 0; r < 24; r++) maze[r] = $urandom & $urandom;
    maze[20][31 - 13] = 1'b0;
    do_reset();
    for (int i = 0; i < 120; i++) begin
      logic [1:0] rd;
      rd = 2'($urandom_range(0, 3));
      move("rand", 1'($urandom_range(0, 1)), rd, 0, 0, 2'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
